ap_txn_profiler: RTL
====================

Name: ap_txn_profiler

Overview:
Synthesizable on-chip profiler for one ap_ctrl_hs HLS kernel with a single pipelined loop. It samples the kernel's start/ready/done/continue handshake and the loop's per-iteration retire strobe. For each transaction it produces one record: start timestamp, latency, start-to-start interval, retired iterations and an incomplete flag. Records leave through a small valid/ready FIFO, which feeds the status/CSV dump stage.

Parameters:
TS_W, 32, width of free-running timestamp and of latency/interval fields
CNT_W, 16, width of iteration counter and of overflow counter
FIFO_DEPTH, 4, record FIFO depth (power of two, >=2)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high reset
ap_start  in  1  kernel start (from kernel driver)
ap_ready  in  1  kernel ready (observed only; not required for records)
ap_done  in  1  kernel done pulse
ap_continue  in  1  kernel continue (tie 1 when unused)
iter_end  in  1  one-cycle strobe per retired pipeline iteration (last-stage enable & !subdone)
finish  in  1  end of run; closes any open transaction
rec_valid  out  1  record available
rec_ready  in  1  consumer accepts record
rec_start_ts  out  TS_W  timestamp of transaction start
rec_latency  out  TS_W  done timestamp minus start timestamp, modulo 2^TS_W
rec_interval  out  TS_W  start minus previous start; 0 for first transaction since reset
rec_iters  out  CNT_W  retired iterations, saturating
rec_incomplete  out  1  record closed by finish, not by ap_done
overflow_cnt  out  CNT_W  records dropped on full FIFO, saturating
busy  out  1  high in RUN or DONE_WAIT

Behaviour:
- Reset (async, active-high) clears everything: ts=0, state IDLE, FIFO empty, rec_valid=0, all rec_* fields 0, overflow_cnt=0, busy=0, first-flag set. Reset mid-transaction discards it with no record.
- ts increments every cycle after reset and wraps; latency and interval use modulo subtraction, so they are correct across a wrap.
- FSM:
  - IDLE: ap_start=1 -> capture t_start=ts, interval=(first ? 0 : ts - t_prev), t_prev=ts, clear first-flag, iters=0, go RUN.
  - RUN: iter_end increments iters, saturating at 2^CNT_W-1. This includes an iter_end in the same cycle as ap_done.
    - On ap_done: latency=ts - t_start, push record. Then ap_continue=1 -> IDLE, else -> DONE_WAIT.
  - DONE_WAIT: stay until ap_continue=1, then IDLE. iter_end is ignored here.
  - HALT: entered from any state when finish=1. Terminal until reset; ap_start ignored.
- Minimum structural gap is one cycle: the cycle after ap_done is IDLE, and a held ap_start starts the next transaction there.
- finish in RUN, without ap_done that cycle: push record with latency=ts - t_start and rec_incomplete=1, then HALT.
- finish and ap_done in the same cycle: push a normal record (incomplete=0), then HALT.
- finish in IDLE or DONE_WAIT: no record, HALT.
- FIFO and output handshake:
  - Push succeeds if not full, or if a pop occurs in the same cycle (rec_valid & rec_ready).
  - Otherwise the record is dropped and overflow_cnt increments, saturating.
  - rec_* are driven from the FIFO head and are stable while rec_valid=1 and rec_ready=0.
  - First-word latency: a record pushed in cycle N is visible with rec_valid=1 in cycle N+1.
- ap_ready does not affect FSM behaviour; it is an input only for future use and assertions.
- Simultaneous ap_start in IDLE and finish: finish wins, no transaction opened.

Decomposition:
- Package ap_prof_pkg holds:
  - typedef prof_state_e (IDLE, RUN, DONE_WAIT, HALT)
  - packed struct prof_rec_t {start_ts, latency, interval, iters, incomplete}, widths from package localparams mirroring defaults
  - function sat_inc
- One sub-module, prof_rec_fifo: synchronous FIFO of prof_rec_t, with push/pop, full/empty, same-cycle push-on-full-with-pop allowed and asynchronous active-high reset.
- The top holds the timestamp, FSM and counters.

Test Plan:
- Single transaction: reset release at ts=0; ap_start at ts=5; 8 iter_end pulses; ap_done at ts=20, continue=1 -> one record {start_ts=5, latency=15, interval=0, iters=8, incomplete=0}, rec_valid at ts=21.
- Back-to-back with held ap_start: first start ts=5, done ts=20; ap_start held -> second start ts=21; done ts=36 -> second record interval=16, latency=15.
- ap_continue low: done at ts=20 with continue=0 until ts=30, iter_end pulses at ts=25 -> no iteration counted; next start no earlier than ts=31; busy=1 through ts=30.
- Backpressure overflow: FIFO_DEPTH=4, rec_ready=0, 6 transactions -> 4 records retained in order, overflow_cnt=2. Then a push on full with rec_ready=1 in the same cycle -> accepted, overflow_cnt stays 2.
- Finish mid-run: start ts=10, 3 iter_end, finish at ts=40 -> record {latency=30, iters=3, incomplete=1}; later ap_start produces nothing.
- Wrap and reset: TS_W=8; start ts=250, done ts=260 (ts reads 4) -> latency=10. Async reset asserted mid-RUN -> rec_valid=0 immediately, no record after release.

Source files
------------

// File: rtl/ap_prof_pkg.sv
// Shared types and helpers for the ap_ctrl_hs transaction profiler.
package ap_prof_pkg;

   localparam int PROF_TS_W  = 32;
   localparam int PROF_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      DONE_WAIT = 2'd2,
      HALT      = 2'd3
   } prof_state_e;

   // One profiling record per kernel transaction, as seen at the FIFO head.
   typedef struct packed {
      logic [PROF_TS_W-1:0]  start_ts;
      logic [PROF_TS_W-1:0]  latency;
      logic [PROF_TS_W-1:0]  interval;
      logic [PROF_CNT_W-1:0] iters;
      logic                  incomplete;
   } prof_rec_t;

   // Increment v, holding at 2^w-1 (w up to 32). Callers truncate the result to w bits.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] max_v;
      max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= max_v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/prof_rec_fifo.sv
// Small show-ahead record FIFO. A push while full is still accepted when a pop
// happens in the same cycle; otherwise it is dropped and flagged on push_drop.
module prof_rec_fifo
   import ap_prof_pkg::*;
#(
   parameter type rec_t = prof_rec_t,
   parameter int  DEPTH = 4
)(
   input  logic clock,
   input  logic reset,
   input  logic push,
   input  rec_t push_data,
   input  logic pop,
   output rec_t head,
   output logic full,
   output logic empty,
   output logic push_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   rec_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   // Pointer/occupancy update; a pop frees the slot a same-cycle push needs.
   always_comb begin
      full      = (count_q == CNT_MAX);
      empty     = (count_q == '0);
      do_pop    = pop && !empty;
      do_push   = push && (!full || do_pop);
      push_drop = push && !do_push;
      wr_ptr_d  = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d  = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d   = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!do_push && do_pop) begin
         count_d = count_q - CNT_ONE;
      end
      head = empty ? '0 : mem_q[rd_ptr_q];
   end

   // Storage array, left unreset so it can map onto distributed RAM.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // Control registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/ap_txn_profiler.sv
// Profiler for one ap_ctrl_hs kernel: timestamps each transaction, counts
// retired loop iterations and queues one record per transaction.
module ap_txn_profiler
   import ap_prof_pkg::*;
#(
   parameter int TS_W       = 32,
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 4
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   input  logic             ap_continue,
   input  logic             iter_end,
   input  logic             finish,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [TS_W-1:0]  rec_start_ts,
   output logic [TS_W-1:0]  rec_latency,
   output logic [TS_W-1:0]  rec_interval,
   output logic [CNT_W-1:0] rec_iters,
   output logic             rec_incomplete,
   output logic [CNT_W-1:0] overflow_cnt,
   output logic             busy
);

   typedef struct packed {
      logic [TS_W-1:0]  start_ts;
      logic [TS_W-1:0]  latency;
      logic [TS_W-1:0]  interval;
      logic [CNT_W-1:0] iters;
      logic             incomplete;
   } rec_t;

   prof_state_e      state_q, state_d;
   logic [TS_W-1:0]  ts_q, ts_d;
   logic [TS_W-1:0]  t_start_q, t_start_d;
   logic [TS_W-1:0]  t_prev_q, t_prev_d;
   logic [TS_W-1:0]  interval_q, interval_d;
   logic [CNT_W-1:0] iters_q, iters_d;
   logic [CNT_W-1:0] ovf_q, ovf_d;
   logic             first_q, first_d;
   logic [CNT_W-1:0] iters_cnt;
   logic             push;
   rec_t             push_rec;
   rec_t             head;
   logic             fifo_full, fifo_empty, fifo_drop;

   // ap_ready is observed only; it never steers the FSM.
   logic unused_ap_ready;
   assign unused_ap_ready = ap_ready;

   // Transaction FSM, timestamp and record assembly.
   always_comb begin
      ts_d       = ts_q + TS_W'(1);
      state_d    = state_q;
      t_start_d  = t_start_q;
      t_prev_d   = t_prev_q;
      interval_d = interval_q;
      iters_d    = iters_q;
      first_d    = first_q;
      push       = 1'b0;
      push_rec   = '0;
      iters_cnt  = iter_end ? CNT_W'(sat_inc(32'(iters_q), CNT_W)) : iters_q;
      unique case (state_q)
         IDLE: begin
            if (finish) begin
               state_d = HALT;
            end else if (ap_start) begin
               t_start_d  = ts_q;
               interval_d = first_q ? '0 : ts_q - t_prev_q;
               t_prev_d   = ts_q;
               first_d    = 1'b0;
               iters_d    = '0;
               state_d    = RUN;
            end
         end
         RUN: begin
            iters_d = iters_cnt;
            if (ap_done || finish) begin
               push                = 1'b1;
               push_rec.start_ts   = t_start_q;
               push_rec.latency    = ts_q - t_start_q;
               push_rec.interval   = interval_q;
               push_rec.iters      = iters_cnt;
               // A done in the same cycle as finish still counts as a normal close.
               push_rec.incomplete = !ap_done;
            end
            if (finish) begin
               state_d = HALT;
            end else if (ap_done) begin
               state_d = ap_continue ? IDLE : DONE_WAIT;
            end
         end
         DONE_WAIT: begin
            if (finish) begin
               state_d = HALT;
            end else if (ap_continue) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = HALT;
         end
      endcase
      ovf_d = fifo_drop ? CNT_W'(sat_inc(32'(ovf_q), CNT_W)) : ovf_q;
   end

   // State registers; reset discards any open transaction.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ts_q       <= '0;
         t_start_q  <= '0;
         t_prev_q   <= '0;
         interval_q <= '0;
         iters_q    <= '0;
         ovf_q      <= '0;
         first_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         ts_q       <= ts_d;
         t_start_q  <= t_start_d;
         t_prev_q   <= t_prev_d;
         interval_q <= interval_d;
         iters_q    <= iters_d;
         ovf_q      <= ovf_d;
         first_q    <= first_d;
      end
   end

   prof_rec_fifo #(
      .rec_t (rec_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_rec),
      .pop       (rec_ready),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .push_drop (fifo_drop)
   );

   // Output view of the FIFO head and status.
   always_comb begin
      rec_valid      = !fifo_empty;
      rec_start_ts   = head.start_ts;
      rec_latency    = head.latency;
      rec_interval   = head.interval;
      rec_iters      = head.iters;
      rec_incomplete = head.incomplete;
      overflow_cnt   = ovf_q;
      busy           = (state_q == RUN) || (state_q == DONE_WAIT);
   end

   logic unused_full;
   assign unused_full = fifo_full;

endmodule
